// File: rtl/rally_arbiter.sv
// rally_arbiter: referee FSM granting serve/return rights, scoring landings and ending the game at WIN_SCORE.
module rally_arbiter #(
  parameter int WIN_SCORE  = 11,
  parameter int POINT_HOLD = 60,
  parameter int SCORE_W    = 4
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               shoot1,
  input  logic               shoot2,
  input  logic               hit1,
  input  logic               hit2,
  input  logic               landed,
  input  logic               land_side,
  output logic               serve_en1,
  output logic               serve_en2,
  output logic               hit_en1,
  output logic               hit_en2,
  output logic               server,
  output logic               last_hitter,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               point_flash,
  output logic               game_over,
  output logic               winner,
  output logic [1:0]         state
);
  localparam int CW = $clog2(POINT_HOLD + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  typedef enum logic [1:0] {SERVE, RALLY, POINT, OVER} state_t;
  state_t st, st_n;
  logic server_n, last_n, winner_n, hit1_q, hit2_q, acc_hit, done;
  logic [SCORE_W-1:0] score1_n, score2_n;
  logic [CW-1:0] cnt, cnt_n;
  // Only the receiver's fresh rising edge may take ownership of the shuttle.
  assign acc_hit = last_hitter ? (hit1 & ~hit1_q) : (hit2 & ~hit2_q);
  assign done = (score1 >= WIN) || (score2 >= WIN);
  assign serve_en1 = (st == SERVE) & ~server;
  assign serve_en2 = (st == SERVE) & server;
  assign hit_en1 = (st == RALLY) & last_hitter;
  assign hit_en2 = (st == RALLY) & ~last_hitter;
  assign point_flash = st == POINT;
  assign game_over = st == OVER;
  assign state = st;
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      st <= SERVE;
      server <= 1'b0;
      last_hitter <= 1'b0;
      score1 <= '0;
      score2 <= '0;
      cnt <= '0;
      winner <= 1'b0;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
    end else begin
      st <= st_n;
      server <= server_n;
      last_hitter <= last_n;
      score1 <= score1_n;
      score2 <= score2_n;
      cnt <= cnt_n;
      winner <= winner_n;
      hit1_q <= hit1;
      hit2_q <= hit2;
    end
  end
  always_comb begin
    st_n = st;
    server_n = server;
    last_n = last_hitter;
    score1_n = score1;
    score2_n = score2;
    cnt_n = cnt;
    winner_n = winner;
    case (st)
      SERVE: if (server ? shoot2 : shoot1) begin
        st_n = RALLY;
        last_n = server;
      end
      RALLY: if (landed) begin
        // The point goes to the figure whose half the shuttle did not land in.
        st_n = POINT;
        server_n = ~land_side;
        score1_n = (land_side && score1 != '1) ? score1 + 1'b1 : score1;
        score2_n = (!land_side && score2 != '1) ? score2 + 1'b1 : score2;
      end else if (acc_hit) last_n = ~last_hitter;
      POINT: if (cnt == CW'(POINT_HOLD - 1)) begin
        cnt_n = '0;
        st_n = done ? OVER : SERVE;
        winner_n = done ? (score1 < WIN) : winner;
      end else cnt_n = cnt + 1'b1;
      OVER: if (start) begin
        st_n = SERVE;
        score1_n = '0;
        score2_n = '0;
        server_n = 1'b0;
        last_n = 1'b0;
      end
      default: st_n = SERVE;
    endcase
  end
endmodule

// File: tb/tb_rally_arbiter.sv
// tb_rally_arbiter: directed and random stimulus scored against a rule-level referee model via an expectation queue.
module tb_rally_arbiter;
  localparam int WIN = 3;
  localparam int HOLD = 40;
  localparam int SW = 4;
  logic frame_clk = 0, Reset = 1, start = 0, shoot1 = 0, shoot2 = 0, hit1 = 0, hit2 = 0, landed = 0, land_side = 0;
  logic serve_en1, serve_en2, hit_en1, hit_en2, server, last_hitter, point_flash, game_over, winner;
  logic [SW-1:0] score1, score2;
  logic [1:0] state;
  typedef struct packed {
    logic [1:0] st;
    logic sv, lh;
    logic [SW-1:0] s1, s2;
    logic se1, se2, he1, he2, pf, go, wn;
  } obs_t;
  obs_t exp_q[$];
  int checks = 0, fails = 0;
  // referee model: phase 0 serve, 1 rally, 2 point, 3 over
  int m_phase = 0, m_server = 0, m_owner = 0, m_p1 = 0, m_p2 = 0, m_frames = 0, m_champ = 0, m_h1 = 0, m_h2 = 0;
  bit r_h1 = 0, r_h2 = 0;
  rally_arbiter #(.WIN_SCORE(WIN), .POINT_HOLD(HOLD), .SCORE_W(SW)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .start(start), .shoot1(shoot1), .shoot2(shoot2),
    .hit1(hit1), .hit2(hit2), .landed(landed), .land_side(land_side),
    .serve_en1(serve_en1), .serve_en2(serve_en2), .hit_en1(hit_en1), .hit_en2(hit_en2),
    .server(server), .last_hitter(last_hitter), .score1(score1), .score2(score2),
    .point_flash(point_flash), .game_over(game_over), .winner(winner), .state(state)
  );
  always #5 frame_clk = ~frame_clk;
  function automatic obs_t predict();
    obs_t o;
    o.st = 2'(m_phase);
    o.sv = m_server[0];
    o.lh = m_owner[0];
    o.s1 = SW'(m_p1);
    o.s2 = SW'(m_p2);
    o.se1 = m_phase == 0 && m_server == 0;
    o.se2 = m_phase == 0 && m_server == 1;
    o.he1 = m_phase == 1 && m_owner == 1;
    o.he2 = m_phase == 1 && m_owner == 0;
    o.pf = m_phase == 2;
    o.go = m_phase == 3;
    o.wn = m_champ[0];
    return o;
  endfunction
  task automatic referee(input bit rst, st_i, sh1, sh2, h1, h2, ld, ls);
    bit fresh1 = h1 && m_h1 == 0;
    bit fresh2 = h2 && m_h2 == 0;
    int top = (1 << SW) - 1;
    if (rst) begin
      m_phase = 0; m_server = 0; m_owner = 0; m_p1 = 0; m_p2 = 0; m_frames = 0; m_champ = 0; m_h1 = 0; m_h2 = 0;
      return;
    end
    if (m_phase == 0) begin
      if ((m_server == 0 && sh1) || (m_server == 1 && sh2)) begin m_phase = 1; m_owner = m_server; end
    end else if (m_phase == 1) begin
      if (ld) begin
        m_phase = 2;
        m_frames = 0;
        if (ls) begin m_p1 = m_p1 < top ? m_p1 + 1 : top; m_server = 0; end
        else begin m_p2 = m_p2 < top ? m_p2 + 1 : top; m_server = 1; end
      end else if (m_owner == 1 && fresh1) m_owner = 0;
      else if (m_owner == 0 && fresh2) m_owner = 1;
    end else if (m_phase == 2) begin
      m_frames++;
      if (m_frames == HOLD) begin
        m_frames = 0;
        if (m_p1 >= WIN) begin m_phase = 3; m_champ = 0; end
        else if (m_p2 >= WIN) begin m_phase = 3; m_champ = 1; end
        else m_phase = 0;
      end
    end else if (st_i) begin
      m_phase = 0; m_p1 = 0; m_p2 = 0; m_server = 0; m_owner = 0;
    end
    m_h1 = h1;
    m_h2 = h2;
  endtask
  task automatic drive(input bit rst, st_i, sh1, sh2, h1, h2, ld, ls);
    @(negedge frame_clk);
    Reset = rst; start = st_i; shoot1 = sh1; shoot2 = sh2; hit1 = h1; hit2 = h2; landed = ld; land_side = ls;
    referee(rst, st_i, sh1, sh2, h1, h2, ld, ls);
    exp_q.push_back(predict());
  endtask
  task automatic idle(input int n, input bit h1 = 0, input bit h2 = 0);
    repeat (n) drive(0, 0, 0, 0, h1, h2, 0, 0);
  endtask
  task automatic serve_and_land(input bit ls);
    drive(0, 0, m_server == 0, m_server == 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, ls);
  endtask
  initial begin
    obs_t act, e;
    forever begin
      @(posedge frame_clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = '{state, server, last_hitter, score1, score2, serve_en1, serve_en2, hit_en1, hit_en2, point_flash, game_over, winner};
        checks++;
        if (act != e) begin
          fails++;
          $display("FAIL frame t=%0t: got st=%0d sv=%0b lh=%0b s1=%0d s2=%0d en=%b%b%b%b pf=%0b go=%0b w=%0b, want st=%0d sv=%0b lh=%0b s1=%0d s2=%0d en=%b%b%b%b pf=%0b go=%0b w=%0b",
            $time, act.st, act.sv, act.lh, act.s1, act.s2, act.se1, act.se2, act.he1, act.he2, act.pf, act.go, act.wn,
            e.st, e.sv, e.lh, e.s1, e.s2, e.se1, e.se2, e.he1, e.he2, e.pf, e.go, e.wn);
        end
      end
    end
  end
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    idle(5, 0, 1);
    idle(1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    idle(HOLD + 1);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1, 1);
    idle(HOLD + 1);
    repeat (2) begin serve_and_land(1); idle(HOLD + 1); end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    serve_and_land(0);
    idle(30);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 1, 0, 1, 0, 0, 0);
    idle(2);
    repeat (4000) begin
      if ($urandom_range(0, 2) == 0) r_h1 = ~r_h1;
      if ($urandom_range(0, 2) == 0) r_h2 = ~r_h2;
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, r_h1, r_h2, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end
    idle(2);
    @(negedge frame_clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rally_arbiter.md
# rally_arbiter

Rally referee and shuttle-ownership arbiter for the two-player badminton game. It decides which stick figure may serve and which may return. It accepts serve and hit events from the two figure FSMs and converts shuttle landings into points. It also keeps the score and ends the game at a target score. It runs in the frame domain, sits between the two figure FSMs and the shuttle physics block, and drives the score display.

## Interface
Parameters:
- WIN_SCORE, 11: point total that ends the game; 1..2^SCORE_W-1.
- POINT_HOLD, 60: frames spent in POINT after a landing (1 s at 60 Hz); ≥1.
- SCORE_W, 4: width of each score counter.

Ports:
- frame_clk  in  1  frame clock (~60 Hz); all state advances on its rising edge.
- Reset  in  1  synchronous, active-high.
- start  in  1  level; leaves OVER and begins a new game.
- shoot1, shoot2  in  1  serve pulse from figure 1 / figure 2 (ball_shoot).
- hit1, hit2  in  1  swing-active level from figure 1 / figure 2 (ball_hit); multi-frame.
- landed  in  1  one-frame pulse from shuttle physics when the shuttle reaches the floor.
- land_side  in  1  valid with landed; 0 = figure 1 half, 1 = figure 2 half.
- serve_en1, serve_en2  out  1  the figure is permitted to serve.
- hit_en1, hit_en2  out  1  the figure is permitted to return.
- server  out  1  0 = figure 1 serves next, 1 = figure 2.
- last_hitter  out  1  owner of the shuttle in flight.
- score1, score2  out  SCORE_W  points.
- point_flash  out  1  high throughout POINT.
- game_over  out  1  high in OVER.
- winner  out  1  valid while game_over; 0 = figure 1.
- state  out  2  SERVE=0, RALLY=1, POINT=2, OVER=3.

## Operation
- Reset values: state=SERVE, server=0, last_hitter=0, scores=0, hold counter=0, hit edge registers=0, winner=0.
- Edge detection: hitN_q registers hitN every frame in every state. Accepted hit = hitN & ~hitN_q.
- SERVE:
  - serve_en of the current server = 1. All other enables = 0.
  - A shoot pulse from the server → RALLY, last_hitter=server.
  - A shoot from the non-server is ignored. landed and hits are ignored.
- RALLY:
  - hit_en of the receiver (~last_hitter) = 1. The other enable = 0. serve_en* = 0.
  - A rising hit edge from the receiver → last_hitter = receiver.
  - A hit from last_hitter is ignored (no double hit).
  - Simultaneous rising edges from both figures: only the receiver's edge counts.
  - landed → POINT. The point goes to the figure opposite land_side: land_side=0 → score2+1, server=1; land_side=1 → score1+1, server=0.
  - landed together with an accepted hit: landed wins and the hit is discarded.
- Score increment saturates at 2^SCORE_W-1.
- POINT:
  - All enables = 0. point_flash = 1. The counter counts from 0.
  - On the frame where counter == POINT_HOLD-1: if either score ≥ WIN_SCORE → OVER, winner = that figure; otherwise → SERVE. The counter is cleared on exit.
- OVER:
  - All enables = 0. game_over = 1. Scores and winner are held.
  - start=1 → SERVE with scores=0, server=0, last_hitter=0.
  - start is ignored in every other state.
- shoot*, landed and start are ignored outside the states listed above.
- Unused state encodings are impossible; recovery is to SERVE.

## Timing
- Every output is a register or a decode of registered state only. There is no combinational path from input to output.
- Event latency: an event sampled at edge N is visible on outputs after edge N. Example: a shoot at edge N gives state=RALLY and hit_en of the receiver = 1 starting that cycle.
- POINT duration: point_flash is high for exactly POINT_HOLD consecutive frames.
- Hold counter width: $clog2(POINT_HOLD+1).
- A hit held across the SERVE→RALLY transition does not count. Only a fresh rising edge is accepted.
- Reset asserted mid-rally or mid-POINT returns every register to its reset value on the next edge. Reset overrides all inputs.

## Test plan
- Serve: reset; shoot2=1 for 1 frame → no change. shoot1=1 → state=1, last_hitter=0, hit_en2=1, hit_en1=0.
- Rally:
  - hit2 rises → last_hitter=1, hit_en1=1.
  - hit2 held 5 frames → no further change.
  - hit2 rises again before hit1 → ignored.
- Point scoring: in RALLY, landed=1 with land_side=0 → state=2, score2=1, server=1, point_flash=1 for 60 frames. Frame 61 → state=0, serve_en2=1.
- Landed/hit collision: landed=1 with land_side=1 and a hit1 rising edge in the same frame → score1+1, last_hitter unchanged.
- Game end: with WIN_SCORE=3 and POINT_HOLD=2, play points to score1=3 → after 2 POINT frames state=3, game_over=1, winner=0. start=1 → scores=0, state=0, server=0.
- Reset mid-operation: assert Reset during POINT with counter=30 → next frame state=0, scores=0, point_flash=0, counter=0.
